ex_hilo: RTL and testbench
==========================

EX_HILO -- requirements
Module: ex_hilo

Interface
REQ-001 Clock  input  1  rising-edge clock for all state.
REQ-002 nReset  input  1  asynchronous, active-low reset.
REQ-003 Valid  input  1  operation request this cycle.
REQ-004 Op  input  3  operation: 0 NOP, 1 MTHI, 2 MTLO, 3 MULT (load product), 4 MADD, 5 MSUB; 6-7 reserved (treated as NOP).
REQ-005 Prod  input  64  product from the execute-stage multiplier.
REQ-006 RsData  input  32  source operand for MTHI/MTLO.
REQ-007 Stall  input  1  pipeline hold; freezes all state while high.
REQ-008 Accept  output  1  request consumed this cycle.
REQ-009 Busy  output  1  accumulate in progress; new requests not accepted.
REQ-010 Hi  output  32  HI register.
REQ-011 Lo  output  32  LO register.
REQ-012 Z  output  1  {Hi,Lo} == 0.
REQ-013 N  output  1  Hi[31].

Function
REQ-014 Accept SHALL be Valid & !Busy & !Stall, combinationally; requests with Accept low SHALL be held by the requester.
REQ-015 Two-state FSM, IDLE and ACC; reset state SHALL be IDLE; Busy SHALL equal (state == ACC).
REQ-016 IDLE, accepted MTHI: Hi <= RsData next edge, Lo unchanged; MTLO symmetric; latency 1.
REQ-017 IDLE, accepted MULT: {Hi,Lo} <= Prod next edge; latency 1; state stays IDLE.
REQ-018 IDLE, accepted MADD/MSUB: Prod and op sign latched into internal 64-bit AccReg; state -> ACC; {Hi,Lo} unchanged this edge.
REQ-019 ACC, Stall low: {Hi,Lo} <= {Hi,Lo} + AccReg (MADD) or {Hi,Lo} - AccReg (MSUB), modulo 2^64, no saturation, no overflow flag; state -> IDLE; total latency 2 edges.
REQ-020 Back-to-back: a request Valid during ACC SHALL be accepted on the first cycle after returning to IDLE and SHALL see the accumulated {Hi,Lo}.
REQ-021 Stall high SHALL hold state, AccReg, Hi and Lo unchanged in every state, including ACC.
REQ-022 NOP and reserved Op with Valid high SHALL assert Accept and change no state.
REQ-023 Z and N SHALL be combinational from the current registered Hi/Lo.
REQ-024 Wrap-around: 0xFFFFFFFF_FFFFFFFF + 1 SHALL give 0 with Z=1; 0 - 1 SHALL give all ones with N=1.

Reset
REQ-025 nReset low SHALL immediately force state IDLE, Hi=0, Lo=0, AccReg=0; Busy=0, Z=1, N=0.
REQ-026 Reset asserted during ACC SHALL abandon the pending accumulate; no partial result SHALL reach Hi/Lo.
REQ-027 After reset deassertion the first Clock edge SHALL accept requests normally.

Configuration
REQ-028 Macro HILO_MADD_EN: defined -> Op 4/5 behave as REQ-018/019 and the ACC state exists.
REQ-029 HILO_MADD_EN undefined -> Op 4/5 treated as NOP (Accept high, no update), AccReg and ACC removed, Busy tied 0.

Verification
REQ-030 Reset then MULT Prod=0x00000002_00000003 -> next edge Hi=0x2, Lo=0x3, Z=0, N=0.
REQ-031 Hi/Lo=0x0_00000005, MADD Prod=0x0_0000000A -> Busy=1 one cycle, then Lo=0xF, Hi=0; Valid-held MTLO RsData=0x7 accepted on the following cycle -> Lo=0x7.
REQ-032 {Hi,Lo}=0, MSUB Prod=1 -> after 2 edges Hi=Lo=0xFFFFFFFF, N=1; MADD Prod=1 -> Hi=Lo=0, Z=1.
REQ-033 MADD accepted, Stall high 3 cycles during ACC -> Hi/Lo and Busy frozen; result appears on the edge after Stall drops.
REQ-034 nReset pulsed low mid-ACC after MADD Prod=0x1234 -> Hi=Lo=0, Busy=0 immediately, no later update.
REQ-035 HILO_MADD_EN undefined, MADD Prod=0x99 -> Accept=1, Busy=0, Hi/Lo unchanged.

Source files
------------

// File: rtl/ex_hilo.sv
// HI/LO register file for the execute stage: MTHI/MTLO moves, MULT load and an optional
// two-cycle multiply-accumulate (MADD/MSUB), compiled in only when HILO_MADD_EN is defined.
module ex_hilo #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [2:0]            op,
    input  logic [2*DATA_W-1:0]   prod,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic                  stall,
    output logic                  accept,
    output logic                  busy,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  z,
    output logic                  n
);

    localparam logic [2:0] OP_MTHI = 3'd1;
    localparam logic [2:0] OP_MTLO = 3'd2;
    localparam logic [2:0] OP_MULT = 3'd3;
`ifdef HILO_MADD_EN
    localparam logic [2:0] OP_MADD = 3'd4;
    localparam logic [2:0] OP_MSUB = 3'd5;

    // Modulo-2^64 accumulate; the pair deliberately wraps with no saturation or flag.
    function automatic logic signed [2*DATA_W-1:0] hilo_accum(
        input logic signed [2*DATA_W-1:0] base,
        input logic signed [2*DATA_W-1:0] addend,
        input logic                       sub
    );
        return sub ? (base - addend) : (base + addend);
    endfunction

    typedef enum logic {IDLE, ACC} state_t;

    state_t                     state;
    logic signed [2*DATA_W-1:0] acc_p0;
    logic                       sub_p0;

    assign busy = (state == ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            acc_p0 <= '0;
            sub_p0 <= 1'b0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            OP_MULT: {hi, lo} <= prod;
                            OP_MADD, OP_MSUB: begin
                                acc_p0 <= prod;
                                sub_p0 <= (op == OP_MSUB);
                                state  <= ACC;
                            end
                            default: ;
                        endcase
                    end
                end
                // Accumulate stage: fold the latched product into the current pair.
                ACC: begin
                    {hi, lo} <= hilo_accum({hi, lo}, acc_p0, sub_p0);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (accept) begin
            case (op)
                OP_MTHI: hi <= rs_data;
                OP_MTLO: lo <= rs_data;
                OP_MULT: {hi, lo} <= prod;
                default: ;
            endcase
        end
    end
`endif

    assign accept = valid & ~busy & ~stall;
    assign z      = ({hi, lo} == '0);
    assign n      = hi[DATA_W-1];

endmodule

// File: tb/tb_ex_hilo.sv
// Directed vector bench for ex_hilo; exercises the accumulate path when HILO_MADD_EN is defined.
module tb_ex_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [2:0]  op;
    logic [63:0] prod;
    logic [31:0] rs_data;
    logic        stall;
    logic        accept;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        n;

    int npass = 0;
    int ntotal = 0;

    ex_hilo dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid),
        .op      (op),
        .prod    (prod),
        .rs_data (rs_data),
        .stall   (stall),
        .accept  (accept),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .z       (z),
        .n       (n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [63:0] prod;
        logic [31:0] rs;
        logic        stall;
        logic        acc;
        logic        bsy;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic v, input logic [2:0] o, input logic [63:0] p,
                                input logic [31:0] r, input logic s, input logic a,
                                input logic b, input logic [31:0] eh, input logic [31:0] el,
                                input logic ez, input logic en);
        vec_t t;
        t.valid = v; t.op = o; t.prod = p; t.rs = r; t.stall = s;
        t.acc = a; t.bsy = b; t.hi = eh; t.lo = el; t.z = ez; t.n = en;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        valid = v.valid; op = v.op; prod = v.prod; rs_data = v.rs; stall = v.stall;
        #1;
        check($sformatf("v%0d accept", idx), 64'(accept), 64'(v.acc));
        @(posedge clk);
        #1;
        check($sformatf("v%0d busy", idx), 64'(busy), 64'(v.bsy));
        check($sformatf("v%0d hi", idx), 64'(hi), 64'(v.hi));
        check($sformatf("v%0d lo", idx), 64'(lo), 64'(v.lo));
        check($sformatf("v%0d z", idx), 64'(z), 64'(v.z));
        check($sformatf("v%0d n", idx), 64'(n), 64'(v.n));
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; op = 3'd0; prod = '0; rs_data = '0; stall = 1'b0;
        #2;
        check("reset hi", 64'(hi), 64'h0);
        check("reset lo", 64'(lo), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset z", 64'(z), 64'h1);
        check("reset n", 64'(n), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //             valid op  prod                    rs            stall acc bsy hi            lo            z  n
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0));
        vq.push_back(mk(1, 3'd3, 64'h00000002_00000003, 32'h0,        0, 1, 0, 32'h2,        32'h3,        0, 0));
        vq.push_back(mk(1, 3'd1, 64'h0,                  32'h80000000, 0, 1, 0, 32'h80000000, 32'h3,        0, 1));
        vq.push_back(mk(1, 3'd2, 64'h0,                  32'hDEADBEEF, 0, 1, 0, 32'h80000000, 32'hDEADBEEF, 0, 1));
        vq.push_back(mk(1, 3'd0, 64'h11111111_11111111, 32'h1234,     0, 1, 0, 32'h80000000, 32'hDEADBEEF, 0, 1));
        vq.push_back(mk(1, 3'd6, 64'h11111111_11111111, 32'h1234,     0, 1, 0, 32'h80000000, 32'hDEADBEEF, 0, 1));
        vq.push_back(mk(1, 3'd7, 64'h11111111_11111111, 32'h1234,     0, 1, 0, 32'h80000000, 32'hDEADBEEF, 0, 1));
        vq.push_back(mk(1, 3'd3, 64'h0,                  32'h0,        1, 0, 0, 32'h80000000, 32'hDEADBEEF, 0, 1));
        vq.push_back(mk(1, 3'd1, 64'h0,                  32'h0,        0, 1, 0, 32'h0,        32'hDEADBEEF, 0, 0));
        vq.push_back(mk(1, 3'd3, 64'h0,                  32'h0,        0, 1, 0, 32'h0,        32'h0,        1, 0));
        vq.push_back(mk(1, 3'd3, 64'h0000000000000005,   32'h0,        0, 1, 0, 32'h0,        32'h5,        0, 0));
`ifdef HILO_MADD_EN
        // MADD then a held MTLO that waits out the ACC cycle
        vq.push_back(mk(1, 3'd4, 64'hA,                  32'h0,        0, 1, 1, 32'h0,        32'h5,        0, 0));
        vq.push_back(mk(1, 3'd2, 64'h0,                  32'h7,        0, 0, 0, 32'h0,        32'hF,        0, 0));
        vq.push_back(mk(1, 3'd2, 64'h0,                  32'h7,        0, 1, 0, 32'h0,        32'h7,        0, 0));
        // 0 - 1 wraps to all ones, then +1 wraps back to zero
        vq.push_back(mk(1, 3'd3, 64'h0,                  32'h0,        0, 1, 0, 32'h0,        32'h0,        1, 0));
        vq.push_back(mk(1, 3'd5, 64'h1,                  32'h0,        0, 1, 1, 32'h0,        32'h0,        1, 0));
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1));
        vq.push_back(mk(1, 3'd4, 64'h1,                  32'h0,        0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1));
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0));
        // borrow across the HI/LO boundary
        vq.push_back(mk(1, 3'd3, 64'h00000001_00000000, 32'h0,        0, 1, 0, 32'h1,        32'h0,        0, 0));
        vq.push_back(mk(1, 3'd5, 64'h1,                  32'h0,        0, 1, 1, 32'h1,        32'h0,        0, 0));
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        0, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 0));
        // stalled MADD request is not taken
        vq.push_back(mk(1, 3'd4, 64'h20,                 32'h0,        1, 0, 0, 32'h0,        32'hFFFFFFFF, 0, 0));
        // stall three cycles inside ACC
        vq.push_back(mk(1, 3'd3, 64'h10,                 32'h0,        0, 1, 0, 32'h0,        32'h10,       0, 0));
        vq.push_back(mk(1, 3'd4, 64'h20,                 32'h0,        0, 1, 1, 32'h0,        32'h10,       0, 0));
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        1, 0, 1, 32'h0,        32'h10,       0, 0));
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        1, 0, 1, 32'h0,        32'h10,       0, 0));
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        1, 0, 1, 32'h0,        32'h10,       0, 0));
        vq.push_back(mk(0, 3'd0, 64'h0,                  32'h0,        0, 0, 0, 32'h0,        32'h30,       0, 0));
        vq.push_back(mk(1, 3'd3, 64'h55,                 32'h0,        0, 1, 0, 32'h0,        32'h55,       0, 0));
        vq.push_back(mk(1, 3'd4, 64'h1234,               32'h0,        0, 1, 1, 32'h0,        32'h55,       0, 0));
`else
        // accumulate ops degrade to NOP
        vq.push_back(mk(1, 3'd4, 64'h99,                 32'h0,        0, 1, 0, 32'h0,        32'h5,        0, 0));
        vq.push_back(mk(1, 3'd5, 64'h99,                 32'h0,        0, 1, 0, 32'h0,        32'h5,        0, 0));
        vq.push_back(mk(1, 3'd3, 64'h55,                 32'h0,        0, 1, 0, 32'h0,        32'h55,       0, 0));
`endif

        foreach (vq[i]) apply(vq[i], i);

        // Asynchronous reset mid-operation: cleared at once, nothing lands afterwards
        @(negedge clk);
        valid = 1'b0; op = 3'd0; rst_n = 1'b0;
        #1;
        check("arst hi", 64'(hi), 64'h0);
        check("arst lo", 64'(lo), 64'h0);
        check("arst busy", 64'(busy), 64'h0);
        check("arst z", 64'(z), 64'h1);
        @(posedge clk);
        #1;
        check("arst hold lo", 64'(lo), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b1; op = 3'd2; rs_data = 32'h7;
        #1;
        check("post-reset accept", 64'(accept), 64'h1);
        @(posedge clk);
        #1;
        check("post-reset lo", 64'(lo), 64'h7);
        check("post-reset hi", 64'(hi), 64'h0);
        check("post-reset busy", 64'(busy), 64'h0);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset idle lo", 64'(lo), 64'h7);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
